// File: rtl/emio_gpio_pkg.sv
// emio_gpio_pkg: shared constants for the EMIO GPIO input return path.
//   EMIO_W       width of the PS7 EMIOGPIOI / EMIOGPIOO buses
//   LEVEL_BASE   first gpio_i bit carrying debounced levels
//   RISE_BASE    first gpio_i bit carrying sticky rise flags
//   FALL_BASE    first gpio_i bit carrying sticky fall flags
//   ACK_BASE     first gpio_o bit carrying per-channel event acknowledge
//   MAX_CH       largest supported channel count (one 16-bit lane per field)
package emio_gpio_pkg;

    localparam int unsigned EMIO_W     = 64;
    localparam int unsigned LEVEL_BASE = 0;
    localparam int unsigned RISE_BASE  = 16;
    localparam int unsigned FALL_BASE  = 32;
    localparam int unsigned ACK_BASE   = 48;
    localparam int unsigned MAX_CH     = 16;

    // Counter width for a debounce window; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/emio_debounce_ch.sv
// emio_debounce_ch: one button channel. Two-flop synchronizer, stability
// counter and debounced level, plus one-cycle rise/fall pulses that fire in
// the same cycle the level is about to change.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive mismatching samples needed to accept a change
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset
//   i_btn    asynchronous board input
//   o_level  debounced level
//   o_rise   one-cycle pulse, level about to go 0 -> 1
//   o_fall   one-cycle pulse, level about to go 1 -> 0
module emio_debounce_ch
    import emio_gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = r_sync ^ r_level;
    // Last mismatching sample of the window: level flips at the coming edge.
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            if (!w_diff) begin
                // Any agreeing sample restarts the window, rejecting glitches.
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_done & r_sync;
    assign o_fall  = w_done & ~r_sync;

endmodule

// File: rtl/emio_gpio_in.sv
// emio_gpio_in: PL-to-PS return path for the EMIO GPIO bank. Debounces N_CH
// board inputs and presents levels plus sticky rise/fall flags on EMIOGPIOI.
// The PS clears a channel's flags with a 0 -> 1 transition on its ack bit.
// Configuration macro: EMIO_GPIO_IN_IRQ_EN builds the registered irq output;
// without it irq is tied low and the PS polls gpio_i.
// Parameters:
//   N_CH             number of input channels, 1..16
//   DEBOUNCE_CYCLES  stable samples required to accept a level change, >= 2
// Ports:
//   clk     FCLKCLK[0]
//   rst     asynchronous active-high reset
//   btn     asynchronous board inputs
//   gpio_o  PS EMIOGPIOO; bits [48+k] acknowledge channel k events
//   gpio_i  to PS EMIOGPIOI: [k] level, [16+k] rise flag, [32+k] fall flag
//   irq     to IRQF2P[0], level, active-high
module emio_gpio_in
    import emio_gpio_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   btn,
    input  logic [EMIO_W-1:0] gpio_o,
    output logic [EMIO_W-1:0] gpio_i,
    output logic              irq
);

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("emio_gpio_in: N_CH must be in 1..16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("emio_gpio_in: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_ack;
    logic [N_CH-1:0] w_ack_pulse;
    logic            w_unused_gpio_o;

    logic [N_CH-1:0] r_rise_flag;
    logic [N_CH-1:0] r_fall_flag;
    logic [N_CH-1:0] r_ack_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        emio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_btn  (btn[k]),
            .o_level(w_level[k]),
            .o_rise (w_rise[k]),
            .o_fall (w_fall[k])
        );
    end

    assign w_ack           = gpio_o[ACK_BASE +: N_CH];
    // Only the 0 -> 1 edge clears, so a held ack does not swallow later events.
    assign w_ack_pulse     = w_ack & ~r_ack_q;
    assign w_unused_gpio_o = ^gpio_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise_flag <= '0;
            r_fall_flag <= '0;
            r_ack_q     <= '0;
        end else begin
            r_ack_q     <= w_ack;
            // Set has priority over a coincident clear.
            r_rise_flag <= w_rise | (r_rise_flag & ~w_ack_pulse);
            r_fall_flag <= w_fall | (r_fall_flag & ~w_ack_pulse);
        end
    end

    always_comb begin
        gpio_i                         = '0;
        gpio_i[LEVEL_BASE +: N_CH]     = w_level;
        gpio_i[RISE_BASE  +: N_CH]     = r_rise_flag;
        gpio_i[FALL_BASE  +: N_CH]     = r_fall_flag;
    end

`ifdef EMIO_GPIO_IN_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |{r_rise_flag, r_fall_flag};
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_emio_gpio_in.sv
// tb_emio_gpio_in: directed stimulus with a scoreboard. Each stimulus step
// queues the bus value {irq, gpio_i} expected at a given cycle; a monitor
// samples on the falling edge and checks every entry whose cycle has arrived.
module tb_emio_gpio_in;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DC   = 4;

`ifdef EMIO_GPIO_IN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [64:0] FULL = {65{1'b1}};
    localparam logic [64:0] IRQB = IRQ_ON ? (65'd1 << 64) : 65'd0;

    typedef struct {
        int unsigned cyc;
        logic [64:0] mask;
        logic [64:0] val;
        string       name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] btn;
    logic [63:0]     gpio_o;
    logic [63:0]     gpio_i;
    logic            irq;

    exp_t        sb_q[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    emio_gpio_in #(
        .N_CH           (N_CH),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .gpio_o(gpio_o),
        .gpio_i(gpio_i),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [64:0] b(input int unsigned n);
        return 65'd1 << n;
    endfunction

    task automatic expect_at(input int unsigned dcyc, input logic [64:0] mask,
                             input logic [64:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dcyc;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Advance n clock edges; inputs then change 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [64:0] act;
        exp_t        e;
        act = {irq, gpio_i};
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: check due at cycle %0d not sampled (now %0d)",
                         e.name, e.cyc, cyc);
            end else if ((act & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s @cycle %0d: got {irq,gpio_i}=%h, want %h (mask %h)",
                         e.name, cyc, act & e.mask, e.val & e.mask, e.mask);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        btn    = '0;
        gpio_o = '0;
        step(3);

        // Idle after reset release.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) expect_at(i, FULL, 65'd0, "reset_idle");
        step(20);

        // Three-cycle glitch on btn[1] must be rejected.
        btn[1] = 1'b1;
        for (int i = 1; i <= 10; i++) expect_at(i, FULL, 65'd0, "glitch_ch1");
        step(3);
        btn[1] = 1'b0;
        step(9);

        // Clean rise on btn[0]: level and flag at edge 6, irq at edge 7.
        btn[0] = 1'b1;
        expect_at(5, FULL, 65'd0, "rise0_pending");
        expect_at(6, FULL, b(0) | b(16), "rise0_level");
        expect_at(7, FULL, b(0) | b(16) | IRQB, "rise0_irq");
        step(8);

        // Ack held high: flag clears at the next edge, irq one edge later.
        gpio_o[48] = 1'b1;
        expect_at(0, FULL, b(0) | b(16) | IRQB, "ack0_before");
        expect_at(1, FULL, b(0) | IRQB, "ack0_clear");
        expect_at(2, FULL, b(0), "ack0_irq_drop");
        step(4);

        // Fall, then rise, with the ack still held: both flags stick.
        btn[0] = 1'b0;
        expect_at(5, FULL, b(0), "fall0_pending");
        expect_at(6, FULL, b(32), "fall0_flag");
        expect_at(7, FULL, b(32) | IRQB, "fall0_irq");
        step(8);
        btn[0] = 1'b1;
        expect_at(6, FULL, b(0) | b(16) | b(32) | IRQB, "rise0_reflag");
        expect_at(12, FULL, b(0) | b(16) | b(32) | IRQB, "rise0_held_ack");
        step(13);

        // Channel 2: ack pulse coincides with the fall pulse; set wins.
        btn[2] = 1'b1;
        expect_at(6, FULL, b(0) | b(16) | b(32) | b(2) | b(18) | IRQB, "rise2");
        step(8);
        btn[2] = 1'b0;
        expect_at(5, FULL, b(0) | b(16) | b(32) | b(2) | b(18) | IRQB, "fall2_pending");
        expect_at(6, FULL, b(0) | b(16) | b(32) | b(34) | IRQB, "ack2_fall2_same");
        expect_at(8, FULL, b(0) | b(16) | b(32) | b(34) | IRQB, "fall2_kept");
        step(5);
        gpio_o[50] = 1'b1;
        step(4);

        // Reset mid-count on btn[3] clears everything asynchronously.
        btn[3] = 1'b1;
        expect_at(2, FULL, b(0) | b(16) | b(32) | b(34) | IRQB, "pre_reset");
        step(3);
        rst = 1'b1;
        expect_at(0, FULL, 65'd0, "reset_async");
        expect_at(1, FULL, 65'd0, "reset_held");
        expect_at(2, FULL, 65'd0, "reset_held");
        step(3);

        // Inputs held high through reset rise DC+2 edges after release.
        rst = 1'b0;
        for (int i = 0; i <= 5; i++) expect_at(i, FULL, 65'd0, "post_reset_wait");
        expect_at(6, FULL, b(0) | b(3) | b(16) | b(19), "post_reset_rise");
        expect_at(7, FULL, b(0) | b(3) | b(16) | b(19) | IRQB, "post_reset_irq");
        step(9);

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) step(1);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/emio_gpio_in.md
# emio_gpio_in

PL-to-PS return path for the EMIO GPIO bank: samples asynchronous board inputs (buttons), synchronizes and debounces each one, and drives the PS7 `EMIOGPIOI` bus with debounced levels plus sticky rise/fall event flags. The PS acknowledges events through dedicated `EMIOGPIOO` bits. An optional interrupt line feeds `IRQF2P`. It sits in `top` between the board pins and the PS7 instance, replacing the constant-zero tie-off on `EMIOGPIOI`.

## Interface
- `N_CH`, 4: number of input channels, 1..16.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronized samples required to accept a level change, ≥2.
- `clk` input 1: single clock, `FCLKCLK[0]`; `gpio_o` is synchronous to it.
- `rst` input 1: asynchronous, active-high reset.
- `btn` input N_CH: asynchronous board inputs.
- `gpio_o` input 64: PS `EMIOGPIOO`; bits [48+k] are per-channel event acknowledge.
- `gpio_i` output 64: to PS `EMIOGPIOI`.
- `irq` output 1: to `IRQF2P[0]`, level, active-high.

## Operation
- Per channel k:
  - Two-flop synchronizer `btn[k]` -> `s[k]`.
  - Debounced state `d[k]`.
  - Counter `cnt[k]`, width $clog2(DEBOUNCE_CYCLES).
- Debounce:
  - If `s==d`, `cnt` <= 0.
  - Otherwise, if `cnt==DEBOUNCE_CYCLES-1`, then `d` <= `s`, `cnt` <= 0, and a one-cycle `rise` (s=1) or `fall` (s=0) pulse is produced.
  - Otherwise `cnt` increments.
  - Any mismatch-free sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Sticky events:
  - `rise_flag[k]` is set by `rise[k]`; `fall_flag[k]` is set by `fall[k]`.
  - Both flags are cleared by `ack_pulse[k]` = `gpio_o[48+k] & ~ack_q[k]`, where `ack_q` is `gpio_o[48+k]` registered.
  - If set and clear occur in the same cycle, set wins.
- `gpio_i` mapping:
  - [k] = `d[k]`
  - [16+k] = `rise_flag[k]`
  - [32+k] = `fall_flag[k]`
  - All other bits, including unused channels, are 0.
- `irq` is a register equal to the OR of all rise/fall flags from the previous cycle.
- Holding an ack bit high clears only once. The PS must return the bit to 0 and write 1 again to clear later events.

## Timing
- Reset values:
  - Outputs: `gpio_i`=0, `irq`=0.
  - Internal: sync flops, `d`, `cnt`, flags and `ack_q` all 0.
- A `btn` change before edge 0 appears at `s` after edge 2. `d`, `gpio_i` level bit and event flag update at edge 1+DEBOUNCE_CYCLES+... precisely at edge 2+DEBOUNCE_CYCLES. `irq` asserts one edge later.
- Ack: `gpio_o[48+k]` rises before edge n, flags clear at edge n, and `irq` deasserts at edge n+1 if no other flag is set.
- A `btn` held high through reset produces a rise event DEBOUNCE_CYCLES+2 cycles after reset release.
- `rst` asserted mid-count discards the pending change immediately and asynchronously.
- A rise and a fall on the same channel before ack leave both flags set. The level bit `d[k]` reflects the current state.

## Configuration
- `EMIO_GPIO_IN_IRQ_EN` defined: the `irq` register is built as described.
- `EMIO_GPIO_IN_IRQ_EN` undefined: `irq` is tied to 0 and no irq register is instantiated. Flags and ack behave identically, and the PS polls `gpio_i`.

## Structure
- Package `emio_gpio_pkg` holds:
  - Constants `LEVEL_BASE`=0, `RISE_BASE`=16, `FALL_BASE`=32, `ACK_BASE`=48, `MAX_CH`=16.
  - The 64-bit EMIO bus width constant.
- Sub-module `emio_debounce_ch`:
  - Contents: synchronizer, counter, `d`, rise/fall pulses.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Instantiated N_CH times with a generate loop.
- Flags, ack edge detect, bus mapping and irq live in `emio_gpio_in`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `N_CH`=4.
- Reset release with `btn`=0: `gpio_i`=0 and `irq`=0 for 20 cycles.
- `btn[0]` 0->1 held: `gpio_i[0]`=1 and `gpio_i[16]`=1 at edge 6, and `irq`=1 at edge 7.
- `btn[1]` high for 3 cycles then low: `gpio_i[1]`, `gpio_i[17]` and `irq` stay 0.
- With `rise_flag[0]` set, drive `gpio_o[48]`=1 and hold it:
  - Flag clears at the next edge and `irq` falls one edge later.
  - A second rise on `btn[0]` while bit 48 stays high sets the flag again and leaves it set.
- `ack_pulse[2]` in the same cycle as `fall[2]`: `gpio_i[34]` remains 1.
- Assert `rst` during a count: all outputs are 0 asynchronously. After release, held `btn[3]`=1 gives `gpio_i[3]`=1 and `gpio_i[19]`=1 6 cycles later.
